// File: rtl/uart_echo_buffer_if.sv
// Byte handshake between uart_echo_buffer and its uart_rx/uart_tx neighbours.
// The slave modport is the echo buffer; the master modport is the UART side.
interface uart_echo_buffer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_en;

  modport master (
    output rx_data,
    output rx_valid,
    output tx_busy,
    input  tx_data,
    input  tx_en
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_busy,
    output tx_data,
    output tx_en
  );
endinterface

// File: rtl/uart_echo_buffer.sv
// Buffered echo engine: queues received bytes in a FIFO and replays them to uart_tx.
// Optional ECHO_UPPERCASE_EN: lowercase ASCII is echoed as uppercase (DATA_W==8 only).
module uart_echo_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_echo_buffer_if.slave      bus,
  input  logic                   clr_ovf,
  output logic [DATA_W-1:0]      last_byte,
  output logic [CNT_W-1:0]       rx_count,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic              tx_en_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [AW-1:0]     rd_ptr_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [FW-1:0]     fill_q,    fill_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [DATA_W-1:0] last_q,    last_d;
  logic              ovf_q,     ovf_d;

  logic pop_c;
  logic full_c;
  logic push_c;
  logic drop_c;

  // Byte as presented to the transmitter; FIFO contents stay raw.
  function automatic logic [DATA_W-1:0] echo_map(input logic [DATA_W-1:0] b);
`ifdef ECHO_UPPERCASE_EN
    if ((DATA_W == 8) && (b >= DATA_W'(8'h61)) && (b <= DATA_W'(8'h7A))) begin
      return b - DATA_W'(8'h20);
    end
`endif
    return b;
  endfunction

  // No bypass: a pop needs a byte already resident, so fill_q gates it.
  assign pop_c  = (state_q == IDLE) && (fill_q != '0) && !bus.tx_busy;
  assign full_c = (fill_q == FW'(DEPTH));
  assign push_c = bus.rx_valid && (!full_c || pop_c);
  assign drop_c = bus.rx_valid && full_c && !pop_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    count_d  = count_q;
    last_d   = last_q;
    ovf_d    = ovf_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CNT_W'(1);
      last_d   = bus.rx_data;
    end

    case ({push_c, pop_c})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and fill.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus.rx_data;
    end
  end

  // TX handshake: pop and strobe together, then follow busy high and back low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop_c) begin
            tx_data_q <= echo_map(mem_q[rd_ptr_q]);
            tx_en_q   <= 1'b1;
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            state_q   <= ACK;
          end
        end
        ACK: begin
          if (bus.tx_busy) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_en   = tx_en_q;
  assign last_byte   = last_q;
  assign rx_count    = count_q;
  assign fill        = fill_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer with a behavioural uart_tx busy model.
// Define ECHO_UPPERCASE_EN for both files to exercise the uppercase echo.
module tb_uart_echo_buffer;

  localparam int unsigned DW       = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CW       = 16;
  localparam int unsigned BUSY_LEN = 20;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic clr_ovf    = 1'b0;
  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;

  logic [DW-1:0]          last_byte;
  logic [CW-1:0]          rx_count;
  logic [$clog2(DEPTH):0] fill;
  logic                   overflow;

  uart_echo_buffer_if #(.DATA_W(DW)) bus ();

  assign bus.tx_busy = model_busy | hold_busy;

  uart_echo_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_ovf   (clr_ovf),
    .last_byte (last_byte),
    .rx_count  (rx_count),
    .fill      (fill),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int   checks      = 0;
  int   failures    = 0;
  int   en_count    = 0;
  int   cyc         = 0;
  int   last_en_cyc = 0;
  logic prev_en     = 1'b0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: every tx_en strobe pops one expected byte.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (rst_n && bus.tx_en) begin
      en_count++;
      last_en_cyc = cyc;
      chk("tx_en_not_consecutive", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_en", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("echo_data", 32'(bus.tx_data), 32'(e));
      end
    end
    prev_en = rst_n && bus.tx_en;
  end

  // uart_tx model: busy rises the cycle after tx_en and lasts BUSY_LEN cycles.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.tx_en) begin
      @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (BUSY_LEN) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input bit echoes, input logic [7:0] e);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (echoes) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    repeat (BUSY_LEN + 6) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_data"},   32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_en"},     32'(bus.tx_en),   32'd0);
    chk({tag, "_last_byte"}, 32'(last_byte),   32'd0);
    chk({tag, "_rx_count"},  32'(rx_count),    32'd0);
    chk({tag, "_fill"},      32'(fill),        32'd0);
    chk({tag, "_overflow"},  32'(overflow),    32'd0);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int rxc;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // Reset values, then a single byte with minimum latency.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = en_count;
    rxc  = cyc;
    send(8'h41, 1'b1, 8'h41);
    n = 0;
    while (en_count == base && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("single_tx_en_seen", 32'(en_count - base), 32'd1);
    chk("single_latency",    32'(last_en_cyc - rxc), 32'd2);
    chk("single_rx_count",   32'(rx_count),  32'd1);
    chk("single_last_byte",  32'(last_byte), 32'h41);
    chk("single_fill",       32'(fill),      32'd0);
    wait_drain(100);

    // Back-to-back burst against a 20-cycle transmitter.
    base = en_count;
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), 1'b1, 8'h31 + 8'(i));
    wait_drain(1000);
    chk("burst_strobes",  32'(en_count - base), 32'd5);
    chk("burst_overflow", 32'(overflow), 32'd0);
    chk("burst_rx_count", 32'(rx_count), 32'd6);

    // Overflow: DEPTH+2 bytes while the transmitter is held busy.
    do_reset();
    base = en_count;
    hold_busy = 1'b1;
    for (int i = 0; i < 18; i++) send(8'h40 + 8'(i), (i < 16), 8'h40 + 8'(i));
    @(negedge clk);
    chk("ovf_fill",      32'(fill),      32'd16);
    chk("ovf_flag",      32'(overflow),  32'd1);
    chk("ovf_rx_count",  32'(rx_count),  32'd16);
    chk("ovf_last_byte", 32'(last_byte), 32'h4F);
    @(posedge clk);
    #1;
    bus.rx_data  = 8'h52;
    bus.rx_valid = 1'b1;
    clr_ovf      = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    clr_ovf      = 1'b0;
    @(negedge clk);
    chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
    chk("ovf_drop_no_count", 32'(rx_count), 32'd16);
    @(posedge clk);
    #1;
    hold_busy = 1'b0;
    wait_drain(2000);
    chk("ovf_echo_count", 32'(en_count - base), 32'd16);
    chk("ovf_sticky",     32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;

    // Full FIFO: push coincides with the pop released by busy falling.
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1, 8'h20 + 8'(i));
    @(negedge clk);
    chk("full_fill", 32'(fill), 32'd16);
    @(posedge clk);
    #1;
    hold_busy    = 1'b0;
    bus.rx_data  = 8'h7E;
    bus.rx_valid = 1'b1;
    exp_q.push_back(8'h7E);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("pushpop_fill",     32'(fill),     32'd16);
    chk("pushpop_overflow", 32'(overflow), 32'd0);
    chk("pushpop_rx_count", 32'(rx_count), 32'd17);
    @(posedge clk);
    #1;
    wait_drain(2000);

    // Reset while draining with three bytes still queued.
    do_reset();
    base = en_count;
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), (i == 0), 8'h11 + 8'(i));
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_pre_fill", 32'(fill), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("midrst_no_tx_en", 32'(en_count - base), 32'd1);
    chk("midrst_fill",     32'(fill), 32'd0);

`ifdef ECHO_UPPERCASE_EN
    send(8'h61, 1'b1, 8'h41);
    send(8'h7A, 1'b1, 8'h5A);
    send(8'h5B, 1'b1, 8'h5B);
    wait_drain(1000);
    chk("upper_last_byte", 32'(last_byte), 32'h5B);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Buffered echo engine between `uart_rx` and `uart_tx` in the echo design. It accepts every received byte into a parametrised FIFO and replays the bytes to the transmitter one at a time, using a busy/enable handshake. This prevents back-to-back characters from being lost while the transmitter is still shifting. It also exports the last accepted byte, a receive counter, FIFO fill level and a sticky overflow flag for `mssd` and debug.

## Interface
- `DATA_W`, 8: character width in bits.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the receive counter.
- `clk` in 1: system clock (100 MHz on board).
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `rx_data` in DATA_W: byte from `uart_rx` `data_out`.
- `rx_valid` in 1: one-cycle strobe from `uart_rx` `data_ready`.
- `tx_busy` in 1: `uart_tx` busy.
- `tx_data` out DATA_W: byte to `uart_tx` `data_in`; held stable until the next pop.
- `tx_en` out 1: one-cycle start strobe to `uart_tx`.
- `last_byte` out DATA_W: most recently accepted byte.
- `rx_count` out CNT_W: accepted-byte count; wraps modulo 2^CNT_W.
- `fill` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a byte is dropped.
- `clr_ovf` in 1: synchronous clear for `overflow`.

## Operation
- Reset values: `tx_data`=0, `tx_en`=0, `last_byte`=0, `rx_count`=0, `fill`=0, `overflow`=0. FIFO pointers are 0 and the FSM is in IDLE.
- Push rule:
  - `rx_valid` high with FIFO not full, or full with a pop in the same cycle: write `rx_data`, increment `rx_count`, update `last_byte`.
  - `rx_valid` high with FIFO full and no pop in the same cycle: byte dropped, `overflow` set. `rx_count` and `last_byte` are unchanged.
- There is no bypass. When the FIFO is empty, a byte must be written before it can be popped.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `fill` is a registered counter: +1 on push only, −1 on pop only, unchanged on push+pop.
- TX FSM:
  - IDLE: if `fill`≠0 and `tx_busy`=0, pop the head into `tx_data`, assert `tx_en` for one cycle, go to ACK.
  - ACK: wait for `tx_busy`=1, then go to DRAIN. `uart_tx` raises busy no later than one cycle after `tx_en`.
  - DRAIN: wait for `tx_busy`=0, then go to IDLE.
- `overflow` priority: a set in the same cycle as `clr_ovf` wins (flag stays 1).
- Reset mid-operation: all state is cleared immediately. A frame already inside `uart_tx` completes on its own. IDLE's `tx_busy`=0 check holds off the next pop until that frame ends.

## Timing
- `rx_valid` in cycle N → FIFO write at the edge ending N; `fill` updates in N+1.
- Empty FIFO, idle TX: `rx_valid` in N → `tx_en` high in N+2. This is the 2-cycle minimum latency.
- Pop and `tx_en` register on the same edge. `tx_data` is valid in the cycle `tx_en` is high and stays stable thereafter.
- Back-to-back echo rate is limited only by `uart_tx`. The next `tx_en` comes at the earliest 2 cycles after `tx_busy` falls (DRAIN→IDLE, IDLE→pop).
- `tx_en` is never high on two consecutive cycles.

## Configuration
- `ECHO_UPPERCASE_EN` defined (effective only when DATA_W==8): on pop, bytes 0x61–0x7A are loaded into `tx_data` as value−0x20 (lowercase echoed as uppercase). The FIFO contents, `last_byte` and `rx_count` still hold the raw bytes.
- `ECHO_UPPERCASE_EN` undefined: `tx_data` is the byte exactly as received.

## Test plan
- Reset then single byte: assert `rst_n`=0 and check all outputs are 0. Release, pulse `rx_valid` with 0x41 → `tx_en` 2 cycles later with `tx_data`=0x41, `rx_count`=1, `last_byte`=0x41, `fill` back to 0.
- Burst: send 5 bytes 0x31..0x35 while `tx_busy` is modelled as a 20-cycle pulse → exactly 5 `tx_en` strobes, in order, each after `tx_busy` falls; no `overflow`.
- Overflow: hold `tx_busy`=1 and push DEPTH+2 bytes (DEPTH=16) → `fill`=16, `overflow`=1, `rx_count`=16. Release busy → the first 16 bytes echo and the 2 extra bytes are absent. `clr_ovf` pulse → `overflow`=0.
- Full with simultaneous push/pop: FIFO full, push arrives in the same cycle as a pop → byte accepted, `fill` stays 16, `overflow` stays 0.
- Reset mid-transfer: assert `rst_n` while in DRAIN with 3 bytes queued → outputs return to 0 and `fill`=0. After release, no `tx_en` occurs until a new `rx_valid`.
- With `ECHO_UPPERCASE_EN` defined: push 0x61, 0x7A, 0x5B → `tx_data` is 0x41, 0x5A, 0x5B in turn; `last_byte` ends at 0x5B.
